heater_seq_ctrl: RTL

//   Soft-start sequencer and error supervisor for a bank of N heater instances. Ramps the

---
 rtl/heater_pkg.sv | 25 ++
 rtl/heater_seq_ctrl_if.sv | 45 ++++
 rtl/heater_pick_lowest.sv | 12 +
 rtl/heater_seq_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/heater_pkg.sv
// Shared types and helpers for the heater soft-start sequencer.
// Channel masks are sized for the largest supported bank and zero-extended by users.
package heater_pkg;

  localparam int MAX_CH   = 64;
  localparam int CH_CNT_W = 7;

  typedef logic [MAX_CH-1:0]   chan_mask_t;
  typedef logic [CH_CNT_W-1:0] chan_cnt_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } seq_state_t;

  function automatic chan_cnt_t popcount(input chan_mask_t mask);
    chan_cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      cnt = cnt + chan_cnt_t'(mask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/heater_seq_ctrl_if.sv
// Control/status bundle between the heater register block and the sequencer.
// master = register block side, slave = sequencer side.
interface heater_seq_ctrl_if #(
  parameter int N     = 16,
  parameter int CNT_W = 16
);

  logic [N-1:0]     req_enable;
  logic [N-1:0]     err_clear_req;
  logic             fault_clear;
  logic [N-1:0]     heater_error;
  logic [N-1:0]     heater_enable;
  logic [N-1:0]     heater_err_clear;
  logic [N-1:0]     err_sticky;
  logic [CNT_W-1:0] err_count;
  logic             busy;
  logic             fault;

  modport master (
    output req_enable,
    output err_clear_req,
    output fault_clear,
    output heater_error,
    input  heater_enable,
    input  heater_err_clear,
    input  err_sticky,
    input  err_count,
    input  busy,
    input  fault
  );

  modport slave (
    input  req_enable,
    input  err_clear_req,
    input  fault_clear,
    input  heater_error,
    output heater_enable,
    output heater_err_clear,
    output err_sticky,
    output err_count,
    output busy,
    output fault
  );

endinterface

// File: rtl/heater_pick_lowest.sv
// One-hot of the lowest set bit of a vector; all-zero in gives all-zero out.
module heater_pick_lowest #(
  parameter int N = 16
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] lowest
);

  // Two's complement isolates the least significant set bit.
  assign lowest = vec & (-vec);

endmodule

// File: rtl/heater_seq_ctrl.sv
// Soft-start sequencer and error supervisor for a bank of N heaters.
// Turns channels on one per STEP_CYCLES, latches errors, trips a bank-wide FAULT.
//
// state    | meaning
// ST_RUN   | enables track target: removals immediate, additions spaced by the step timer
// ST_FAULT | all enables forced off; left via fault_clear once sticky errors drop below threshold
module heater_seq_ctrl
  import heater_pkg::*;
#(
  parameter int N            = 16,
  parameter int STEP_CYCLES  = 1024,
  parameter int CNT_W        = 16,
  parameter int FAULT_THRESH = 4,
  parameter int AUTO_DISABLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  heater_seq_ctrl_if.slave  bus
);

  localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam chan_cnt_t THRESH_C = chan_cnt_t'(FAULT_THRESH);
  localparam logic AUTO_DIS_C = (AUTO_DISABLE != 0);
  localparam int SUM_W = CNT_W + CH_CNT_W;

  seq_state_t        state;
  logic [TMR_W-1:0]  tmr;
  logic [N-1:0]      err_q;

  logic [N-1:0]      target;
  logic [N-1:0]      pending;
  logic [N-1:0]      pick;
  logic [N-1:0]      rise;
  logic [N-1:0]      sticky_nxt;
  chan_mask_t        sticky_ext;
  chan_mask_t        rise_ext;
  chan_cnt_t         sticky_cnt;
  chan_cnt_t         rise_cnt;
  logic [SUM_W-1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              trip;
  logic              step_ok;

  assign target  = bus.req_enable & ~(bus.err_sticky & {N{AUTO_DIS_C}});
  assign pending = target & ~bus.heater_enable;
  assign rise    = bus.heater_error & ~err_q;

  heater_pick_lowest #(.N(N)) u_pick (
    .vec    (pending),
    .lowest (pick)
  );

  always_comb begin
    sticky_ext = '0;
    sticky_ext[N-1:0] = bus.err_sticky;
    rise_ext = '0;
    rise_ext[N-1:0] = rise;
  end

  assign sticky_cnt = popcount(sticky_ext);
  assign rise_cnt   = popcount(rise_ext);
  assign trip       = (sticky_cnt >= THRESH_C);
  assign step_ok    = (tmr == '0) && (pending != '0);

  // A rise on the same cycle as a clear must survive, so the OR comes last.
  assign sticky_nxt = (bus.err_sticky & ~bus.err_clear_req) | rise;

  always_comb begin
    cnt_sum = {{CH_CNT_W{1'b0}}, bus.err_count} + {{CNT_W{1'b0}}, rise_cnt};
    if (cnt_sum > {{CH_CNT_W{1'b0}}, {CNT_W{1'b1}}}) begin
      cnt_nxt = '1;
    end else begin
      cnt_nxt = cnt_sum[CNT_W-1:0];
    end
  end

  assign bus.busy = !rst && (state == ST_RUN) && (bus.heater_enable != target);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ST_RUN;
      tmr                  <= '0;
      err_q                <= '0;
      bus.heater_enable    <= '0;
      bus.heater_err_clear <= '0;
      bus.err_sticky       <= '0;
      bus.err_count        <= '0;
      bus.fault            <= 1'b0;
    end else begin
      err_q                <= bus.heater_error;
      bus.heater_err_clear <= bus.err_clear_req;
      bus.err_sticky       <= sticky_nxt;
      bus.err_count        <= cnt_nxt;

      unique case (state)
        ST_RUN: begin
          if (trip) begin
            state             <= ST_FAULT;
            bus.fault         <= 1'b1;
            bus.heater_enable <= '0;
            tmr               <= TMR_LOAD;
          end else if (step_ok) begin
            bus.heater_enable <= (bus.heater_enable & target) | pick;
            tmr               <= TMR_LOAD;
          end else begin
            bus.heater_enable <= bus.heater_enable & target;
            if (tmr != '0) begin
              tmr <= tmr - TMR_ONE;
            end
          end
        end
        ST_FAULT: begin
          bus.heater_enable <= '0;
          if (tmr != '0) begin
            tmr <= tmr - TMR_ONE;
          end
          if (bus.fault_clear && !trip) begin
            state     <= ST_RUN;
            bus.fault <= 1'b0;
          end
        end
        default: begin
          state             <= ST_RUN;
          bus.fault         <= 1'b0;
          bus.heater_enable <= '0;
        end
      endcase
    end
  end

endmodule
